// File: rtl/jc_decode_mon.sv
// jc_decode_mon: decodes a 4-bit Johnson code to a one-hot phase, checks that the
// sequence advances one step at a time, tracks lock, and counts sequence errors.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   count    in   [3:0] Johnson code from the upstream counter
//   clr_err  in   synchronous clear of err_cnt (wins over a same-cycle error)
//   phase    out  [7:0] one-hot phase of the sampled code, 0 when illegal
//   locked   out  high while the sequence is tracked as valid
//   illegal  out  one-cycle pulse per illegal code
//   skip_err out  one-cycle pulse per legal but out-of-order code
//   err_cnt  out  [ERR_W-1:0] saturating count of illegal + skip events
//
// Build option: define JC_DECODE_ERRCNT_EN to implement err_cnt/clr_err;
// otherwise err_cnt is tied to zero and clr_err is ignored.
module jc_decode_mon #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       count,
    input  logic             clr_err,
    output logic [7:0]       phase,
    output logic             locked,
    output logic             illegal,
    output logic             skip_err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int unsigned IDX_W  = 3;
    localparam int unsigned GOOD_W = 4;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        in_q;
    logic              in_vld;
    logic [IDX_W-1:0]  prev_idx;
    logic              prev_vld;
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] good_cnt_nxt;

    logic              legal_c;
    logic [IDX_W-1:0]  idx_c;
    logic              step_vld_c;
    logic              hold_c;
    logic              good_c;
    logic              skip_c;
    logic              ill_c;

    // Johnson code -> phase index
    always_comb begin
        legal_c = 1'b1;
        idx_c   = '0;
        case (in_q)
            4'b0000: idx_c = 3'd0;
            4'b0001: idx_c = 3'd1;
            4'b0011: idx_c = 3'd2;
            4'b0111: idx_c = 3'd3;
            4'b1111: idx_c = 3'd4;
            4'b1110: idx_c = 3'd5;
            4'b1100: idx_c = 3'd6;
            4'b1000: idx_c = 3'd7;
            default: legal_c = 1'b0;
        endcase
    end

    // Classify the current sample against its predecessor; in_vld masks the
    // reset value of in_q so it is never mistaken for a real sample.
    assign ill_c      = in_vld & ~legal_c;
    assign step_vld_c = in_vld & legal_c & prev_vld;
    assign hold_c     = step_vld_c & (idx_c == prev_idx);
    assign good_c     = step_vld_c & (idx_c == IDX_W'(prev_idx + 3'd1));
    assign skip_c     = step_vld_c & ~hold_c & ~good_c;

    // Input sampling and predecessor tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q     <= '0;
            in_vld   <= 1'b0;
            prev_idx <= '0;
            prev_vld <= 1'b0;
        end else begin
            in_q   <= count;
            in_vld <= 1'b1;
            if (in_vld) begin
                prev_vld <= legal_c;
                if (legal_c) begin
                    prev_idx <= idx_c;
                end
            end
        end
    end

    // Lock FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HUNT;
            good_cnt <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_cnt_nxt;
        end
    end

    // Lock FSM next state
    always_comb begin
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        case (state)
            HUNT: begin
                if (ill_c || skip_c) begin
                    good_cnt_nxt = '0;
                end else if (good_c) begin
                    if (GOOD_W'(good_cnt + 4'd1) >= GOOD_W'(LOCK_CNT)) begin
                        state_nxt    = LOCKED;
                        good_cnt_nxt = '0;
                    end else begin
                        good_cnt_nxt = GOOD_W'(good_cnt + 4'd1);
                    end
                end
            end
            LOCKED: begin
                if (ill_c || skip_c) begin
                    state_nxt    = HUNT;
                    good_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = HUNT;
                good_cnt_nxt = '0;
            end
        endcase
    end

    // Registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= '0;
            locked   <= 1'b0;
            illegal  <= 1'b0;
            skip_err <= 1'b0;
        end else begin
            phase    <= (in_vld && legal_c) ? (8'b1 << idx_c) : 8'h00;
            locked   <= (state_nxt == LOCKED);
            illegal  <= ill_c;
            skip_err <= skip_c;
        end
    end

`ifdef JC_DECODE_ERRCNT_EN
    // Saturating error counter, clear has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= '0;
        end else if ((ill_c || skip_c) && (err_cnt != {ERR_W{1'b1}})) begin
            err_cnt <= ERR_W'(err_cnt + 1'b1);
        end
    end
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_jc_decode_mon.sv
// Bench for jc_decode_mon: directed Johnson-code sequences against a behavioural
// model, plus literal expectations at the key points of each scenario.
module tb_jc_decode_mon;

    localparam int unsigned LOCK_CNT = 4;
`ifdef JC_DECODE_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] count;
    logic       clr_err;

    logic [7:0] phase, phase2;
    logic       locked, locked2, illegal, illegal2, skip_err, skip_err2;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    jc_decode_mon #(.LOCK_CNT(LOCK_CNT), .ERR_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .count(count), .clr_err(clr_err),
        .phase(phase), .locked(locked), .illegal(illegal),
        .skip_err(skip_err), .err_cnt(err_cnt)
    );

    jc_decode_mon #(.LOCK_CNT(LOCK_CNT), .ERR_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .count(count), .clr_err(clr_err),
        .phase(phase2), .locked(locked2), .illegal(illegal2),
        .skip_err(skip_err2), .err_cnt(err_cnt2)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Position of a code in the legal Johnson sequence, -1 if illegal
    function automatic int code_index(input logic [3:0] c);
        logic [3:0] tbl [8];
        tbl = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
        for (int i = 0; i < 8; i++) begin
            if (tbl[i] == c) return i;
        end
        return -1;
    endfunction

    // Behavioural model: outputs for the sample taken on the previous edge
    logic [3:0] m_smp = '0;
    bit         m_smp_vld = 0;
    int         m_prev_idx = 0;
    bit         m_prev_vld = 0;
    int         m_good = 0;
    bit         m_locked = 0;
    logic [7:0] e_phase = '0;
    bit         e_ill = 0, e_skip = 0, e_locked = 0;
    int         e_err = 0, e_err2 = 0;

    always @(posedge clk or negedge rst_n) begin
        int idx;
        bit bad;
        bit good;
        if (!rst_n) begin
            m_smp = '0; m_smp_vld = 0; m_prev_idx = 0; m_prev_vld = 0;
            m_good = 0; m_locked = 0;
            e_phase = '0; e_ill = 0; e_skip = 0; e_locked = 0; e_err = 0; e_err2 = 0;
        end else begin
            bad  = 0;
            good = 0;
            if (m_smp_vld) begin
                idx     = code_index(m_smp);
                e_ill   = (idx < 0);
                e_skip  = 0;
                e_phase = (idx < 0) ? 8'h00 : 8'(1 << idx);
                if (idx < 0) begin
                    bad = 1;
                    m_prev_vld = 0;
                end else begin
                    if (m_prev_vld && idx != m_prev_idx) begin
                        if (idx == (m_prev_idx + 1) % 8) good = 1;
                        else begin
                            e_skip = 1;
                            bad = 1;
                        end
                    end
                    m_prev_vld = 1;
                    m_prev_idx = idx;
                end
                if (bad) begin
                    m_good = 0;
                    m_locked = 0;
                end else if (good && !m_locked) begin
                    m_good++;
                    if (m_good >= LOCK_CNT) begin
                        m_locked = 1;
                        m_good = 0;
                    end
                end
                e_locked = m_locked;
            end
            if (ERR_EN) begin
                if (clr_err) begin
                    e_err = 0;
                    e_err2 = 0;
                end else if (bad) begin
                    e_err  = (e_err < 255) ? e_err + 1 : 255;
                    e_err2 = (e_err2 < 3) ? e_err2 + 1 : 3;
                end
            end
            m_smp = count;
            m_smp_vld = 1;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("phase", phase, e_phase);
            chk("locked", locked, e_locked);
            chk("illegal", illegal, e_ill);
            chk("skip_err", skip_err, e_skip);
            chk("err_cnt", err_cnt, e_err);
            chk("phase_w2", phase2, e_phase);
            chk("locked_w2", locked2, e_locked);
            chk("illegal_w2", illegal2, e_ill);
            chk("skip_err_w2", skip_err2, e_skip);
            chk("err_cnt_w2", err_cnt2, e_err2);
        end
    end

    // Apply one code for one clock; returns on the following falling edge,
    // where outputs reflect the code applied one call earlier.
    task automatic step(input logic [3:0] c, input logic clr);
        count   = c;
        clr_err = clr;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_phase"}, phase, 8'h00);
        chk({tag, "_locked"}, locked, 1'b0);
        chk({tag, "_illegal"}, illegal, 1'b0);
        chk({tag, "_skip"}, skip_err, 1'b0);
        chk({tag, "_err"}, err_cnt, 8'h00);
        chk({tag, "_err_w2"}, err_cnt2, 2'b00);
    endtask

    initial begin
        count   = 4'h0;
        clr_err = 1'b0;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        cmp_en = 1'b1;
        rst_n  = 1'b1;

        // Legal sequence from 0000, lock after four good steps
        step(4'h0, 0); step(4'h1, 0);
        chk("first_phase", phase, 8'h01);
        step(4'h3, 0); step(4'h7, 0); step(4'hF, 0);
        chk("not_locked_yet", locked, 1'b0);
        step(4'hE, 0);
        chk("locked_after_1111", locked, 1'b1);
        chk("no_err_clean_run", err_cnt, 8'h00);
        step(4'hC, 0); step(4'h8, 0); step(4'h0, 0); step(4'h1, 0); step(4'h3, 0);

        // Illegal code while locked, then relock
        step(4'h5, 0); step(4'h7, 0);
        chk("ill_pulse", illegal, 1'b1);
        chk("ill_phase", phase, 8'h00);
        chk("ill_unlock", locked, 1'b0);
        chk("ill_err", err_cnt, ERR_EN ? 8'd1 : 8'd0);
        step(4'hF, 0);
        chk("ill_one_cycle", illegal, 1'b0);
        step(4'hE, 0); step(4'hC, 0); step(4'h8, 0);
        chk("relock_not_yet", locked, 1'b0);
        step(4'h0, 0);
        chk("relock", locked, 1'b1);

        // Skip 0011 -> 1110 while locked
        step(4'h1, 0); step(4'h3, 0); step(4'hE, 0); step(4'hC, 0);
        chk("skip_pulse", skip_err, 1'b1);
        chk("skip_not_ill", illegal, 1'b0);
        chk("skip_phase", phase, 8'h20);
        chk("skip_unlock", locked, 1'b0);
        chk("skip_err_cnt", err_cnt, ERR_EN ? 8'd2 : 8'd0);
        step(4'h8, 0);
        chk("skip_one_cycle", skip_err, 1'b0);

        // Relock, hold 0111 three clocks, wrap 1000 -> 0000
        step(4'h0, 0); step(4'h1, 0); step(4'h3, 0);
        chk("hold_pre_locked", locked, 1'b1);
        step(4'h7, 0); step(4'h7, 0);
        chk("hold_phase_1", phase, 8'h08);
        step(4'h7, 0);
        chk("hold_phase_2", phase, 8'h08);
        step(4'hF, 0);
        chk("hold_phase_3", phase, 8'h08);
        chk("hold_no_skip", skip_err, 1'b0);
        chk("hold_locked", locked, 1'b1);
        step(4'hE, 0); step(4'hC, 0); step(4'h8, 0); step(4'h0, 0); step(4'h1, 0);
        chk("wrap_locked", locked, 1'b1);
        chk("wrap_phase", phase, 8'h01);
        step(4'h3, 0);
        chk("wrap_no_skip", skip_err, 1'b0);

        // Saturation of the 2-bit counter, then clear beats a new error
        repeat (5) step(4'h5, 0);
        step(4'hA, 0);
        chk("err_sat_w2", err_cnt2, ERR_EN ? 2'd3 : 2'd0);
        chk("err_w8_count", err_cnt, ERR_EN ? 8'd7 : 8'd0);
        step(4'h7, 1);
        chk("clr_priority_w2", err_cnt2, 2'd0);
        chk("clr_priority_w8", err_cnt, 8'd0);

        // Relock, then asynchronous reset between edges
        step(4'hF, 0); step(4'hE, 0); step(4'hC, 0); step(4'h8, 0); step(4'h0, 0);
        chk("pre_reset_locked", locked, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(4'h0, 0); step(4'h1, 0); step(4'h3, 0); step(4'h7, 0); step(4'hF, 0);
        chk("post_rst_not_locked", locked, 1'b0);
        step(4'hE, 0);
        chk("post_rst_relock", locked, 1'b1);
        step(4'hC, 0); step(4'h8, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jc_decode_mon.md
JC_DECODE_MON -- requirements
Module: jc_decode_mon

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 4: consecutive good steps needed to declare lock (range 1..15).
REQ-002 SHALL have parameter ERR_W, default 8: width of error counter.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port count  input  4  Johnson code from the upstream Johnson counter.
REQ-006 SHALL have port clr_err  input  1  synchronous clear of err_cnt.
REQ-007 SHALL have port phase  output  8  one-hot decoded phase; all-zero when code illegal.
REQ-008 SHALL have port locked  output  1  high while the sequence is tracked as valid.
REQ-009 SHALL have port illegal  output  1  one-cycle pulse per illegal code sampled.
REQ-010 SHALL have port skip_err  output  1  one-cycle pulse per legal-but-out-of-order code.
REQ-011 SHALL have port err_cnt  output  ERR_W  saturating count of illegal plus skip events.

Function
REQ-012 SHALL treat legal codes, with phase index 0..7, as 0000,0001,0011,0111,1111,1110,1100,1000; all other 8 codes are illegal.
REQ-013 SHALL register count into in_q each clock; evaluation uses in_q; all outputs are registered, so latency is 2 clocks from count to phase/illegal/skip_err/locked.
REQ-014 SHALL drive phase = 1 << index for a legal in_q, 8'h00 for an illegal one.
REQ-015 SHALL classify each sample against the previous sample: hold (same index), good step (index+1 mod 8, 7->0 wrap good), skip (other legal), illegal.
REQ-016 SHALL classify the first legal sample after reset or after an illegal sample as neither good nor skip (no predecessor; prev_vld=0).
REQ-017 SHALL implement FSM HUNT/LOCKED; reset state HUNT; locked=1 only in LOCKED.
REQ-018 SHALL in HUNT increment a good-step counter per good step, leave it unchanged on hold, zero it on skip or illegal; when it reaches LOCK_CNT, enter LOCKED.
REQ-019 SHALL in LOCKED stay on good step or hold; on skip or illegal go to HUNT with good-step counter zeroed.
REQ-020 SHALL not flag a hold as an error in either state.
REQ-021 SHALL increment err_cnt by 1 on each illegal or skip event, saturating at all-ones.
REQ-022 SHALL give clr_err priority: clr_err with a simultaneous error yields err_cnt=0.

Reset
REQ-023 SHALL on rst_n low, without a clock edge, force phase=0, locked=0, illegal=0, skip_err=0, err_cnt=0, in_q=0, prev_vld=0, good counter=0, state HUNT.
REQ-024 SHALL begin sampling count on the first rising clk edge after rst_n deasserts.

Configuration
REQ-025 SHALL with macro JC_DECODE_ERRCNT_EN defined implement err_cnt and clr_err per REQ-021/022.
REQ-026 SHALL with JC_DECODE_ERRCNT_EN undefined tie err_cnt to 0, ignore clr_err, and keep all other behaviour identical.

Verification (LOCK_CNT=4, ERR_W=8, macro defined unless stated)
REQ-027 SHALL cover: reset, then legal sequence from 0000 one per clock -> phase 8'h01 two clocks after 0000 applied, locked=1 two clocks after 1111 applied, no error pulses, err_cnt=0.
REQ-028 SHALL cover: while locked drive 0101 for one clock -> illegal one-cycle pulse, phase=8'h00, locked=0, err_cnt=1; resume legal sequence -> relock after 4 good steps following the first legal code.
REQ-029 SHALL cover: while locked jump 0011 -> 1110 -> skip_err one-cycle pulse, illegal=0, phase=8'h20, locked=0, err_cnt increments by 1.
REQ-030 SHALL cover: hold 0111 for 3 clocks while locked, then 1000->0000 wrap -> no error pulses, phase=8'h08 stable during hold, locked stays 1 across wrap.
REQ-031 SHALL cover: ERR_W=2, 5 illegal codes -> err_cnt=3 (saturated); clr_err together with a further illegal -> err_cnt=0; macro undefined -> err_cnt stays 0 throughout.
REQ-032 SHALL cover: rst_n low mid-LOCKED between clock edges -> all outputs 0 immediately; after release legal sequence relocks after 4 good steps.
